// File: rtl/count_seq_pkg.sv
// Shared definitions for the Count sequencer: state encoding and default sizing.
package count_seq_pkg;

  localparam int COUNT_SEQ_WL    = 8;
  localparam int COUNT_SEQ_STEPS = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/count_seq_table.sv
// STEPS x WL period table: synchronous write, asynchronous read, cleared by reset.
module count_seq_table
  import count_seq_pkg::*;
#(
  parameter int WL    = COUNT_SEQ_WL,
  parameter int STEPS = COUNT_SEQ_STEPS,
  parameter int AW    = $clog2(STEPS)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [WL-1:0] data,
  input  logic [AW-1:0] rd_addr,
  output logic [WL-1:0] rd_data
);

  logic [WL-1:0] mem_q [STEPS];

  logic wr_ok;
  logic rd_ok;

  // Indices past the last entry are dropped on write and read back as zero.
  assign wr_ok = we && (32'(addr) < STEPS);
  assign rd_ok = 32'(rd_addr) < STEPS;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < STEPS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[addr] <= data;
    end
  end

  assign rd_data = rd_ok ? mem_q[rd_addr] : '0;

endmodule

// File: rtl/count_sequencer.sv
// Steps one Count instance through a table of periods; define COUNT_SEQ_LOOP_EN
// to wrap back to entry 0 on the last step instead of ending the run.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WL    = COUNT_SEQ_WL,
  parameter int STEPS = COUNT_SEQ_STEPS,
  parameter int AW    = $clog2(STEPS)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          start,
  input  logic          stop,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [WL-1:0] cfg_data,
  input  logic          rst_flg,
  output logic [WL-1:0] C_P,
  output logic          EN,
  output logic [AW-1:0] step_idx,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic          en_q, en_d;
  logic [WL-1:0] cp_q, cp_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          armed_q;

  logic          tbl_we;
  logic [AW-1:0] rd_addr;
  logic [WL-1:0] rd_data;
  logic          accept;
  logic          last_step;

  count_seq_table #(
    .WL   (WL),
    .STEPS(STEPS),
    .AW   (AW)
  ) u_table (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .we     (tbl_we),
    .addr   (cfg_addr),
    .data   (cfg_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  // Count holds its flag high while disabled, so the first flag after EN rises is stale.
  assign accept    = armed_q && en_q && rst_flg;
  assign last_step = (idx_q == AW'(STEPS - 1));

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    cp_d    = cp_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tbl_we  = 1'b0;
    rd_addr = '0;

    case (state_q)
      IDLE: begin
        en_d   = 1'b0;
        cp_d   = '0;
        busy_d = 1'b0;
        idx_d  = '0;
        tbl_we = cfg_we;
        if (start) begin
          state_d = RUN;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          cp_d    = rd_data;
        end
      end

      RUN: begin
        if (stop) begin
          state_d = IDLE;
          en_d    = 1'b0;
          cp_d    = '0;
          busy_d  = 1'b0;
          idx_d   = '0;
        end else if (accept) begin
          if (!last_step) begin
            rd_addr = idx_q + 1'b1;
            idx_d   = idx_q + 1'b1;
            cp_d    = rd_data;
          end else begin
`ifdef COUNT_SEQ_LOOP_EN
            rd_addr = '0;
            idx_d   = '0;
            cp_d    = rd_data;
            done_d  = 1'b1;
`else
            state_d = DONE;
            en_d    = 1'b0;
            cp_d    = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end

      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        cp_d    = '0;
        busy_d  = 1'b0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      cp_q    <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      cp_q    <= cp_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      armed_q <= en_q;
    end
  end

  assign C_P      = cp_q;
  assign EN       = en_q;
  assign step_idx = idx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
